// File: rtl/jk_excitation_driver.sv
// Drive side of a JK flip-flop link: buffers target bits, issues registered J/K excitation
// from a shadow model of the FF state, and checks q feedback two cycles after each issue.
module jk_excitation_driver #(
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned CNT_W       = 8,
  parameter bit          TOGGLE_PREF = 1'b0,
  parameter bit          RESET_Q     = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_bit,
  output logic             j,
  output logic             k,
  input  logic             q_fb,
  output logic             busy,
  output logic             mismatch,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {StRun, StResync1, StResync2} state_e;

  logic             mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic             j_q, j_d, k_q, k_d;
  logic             pred_q, pred_d;
  logic             s1_v_q, s1_v_d, s1_t_q, s1_t_d;
  logic             s2_v_q, s2_v_d, s2_t_q, s2_t_d;
  logic             mismatch_q, mismatch_d;
  logic [CNT_W-1:0] pass_q, pass_d, err_q, err_d;
  state_e           state_q, state_d;

  logic empty, full, push, pop, head;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign push  = in_valid && !full;
  assign pop   = (state_q == StRun) && !empty;
  assign head  = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    j_d        = 1'b0;
    k_d        = 1'b0;
    pred_d     = pred_q;
    s1_v_d     = 1'b0;
    s1_t_d     = s1_t_q;
    s2_v_d     = s1_v_q;
    s2_t_d     = s1_t_q;
    mismatch_d = 1'b0;
    pass_d     = pass_q;
    err_d      = err_q;
    state_d    = state_q;

    if (push) wr_ptr_d = wr_ptr_q + 1'b1;

    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
      if (pred_q != head) begin
        j_d = TOGGLE_PREF ? 1'b1 : head;
        k_d = TOGGLE_PREF ? 1'b1 : !head;
      end
      pred_d = head;
      s1_v_d = 1'b1;
      s1_t_d = head;
    end

    if (s2_v_q) begin
      if (q_fb == s2_t_q) begin
        if (!(&pass_q)) pass_d = pass_q + 1'b1;
      end else begin
        if (!(&err_q)) err_d = err_q + 1'b1;
        mismatch_d = 1'b1;
        state_d    = StResync1;
        // Flush pending checks: they were issued against a wrong shadow state.
        s1_v_d     = 1'b0;
        s2_v_d     = 1'b0;
      end
    end

    unique case (state_q)
      StResync1: begin
        s1_v_d  = 1'b0;
        s2_v_d  = 1'b0;
        state_d = StResync2;
      end
      StResync2: begin
        pred_d  = q_fb;
        state_d = StRun;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= in_bit;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      j_q        <= 1'b0;
      k_q        <= 1'b0;
      pred_q     <= RESET_Q;
      s1_v_q     <= 1'b0;
      s1_t_q     <= 1'b0;
      s2_v_q     <= 1'b0;
      s2_t_q     <= 1'b0;
      mismatch_q <= 1'b0;
      pass_q     <= '0;
      err_q      <= '0;
      state_q    <= StRun;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      j_q        <= j_d;
      k_q        <= k_d;
      pred_q     <= pred_d;
      s1_v_q     <= s1_v_d;
      s1_t_q     <= s1_t_d;
      s2_v_q     <= s2_v_d;
      s2_t_q     <= s2_t_d;
      mismatch_q <= mismatch_d;
      pass_q     <= pass_d;
      err_q      <= err_d;
      state_q    <= state_d;
    end
  end

  assign in_ready = !full;
  assign j        = j_q;
  assign k        = k_q;
  assign mismatch = mismatch_q;
  assign pass_cnt = pass_q;
  assign err_cnt  = err_q;
  assign busy     = !empty || s1_v_q || s2_v_q || (state_q != StRun);

endmodule

// File: tb/tb_jk_excitation_driver.sv
// Directed bench: three drivers (set/clear, toggle, 2-bit counters) share one stimulus stream,
// each feeding its own behavioural JK flip-flop.
module tb_jk_excitation_driver;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       in_bit;
  logic       stuck;
  logic [2:0] in_ready, j, k, busy, mismatch, ffq, q_fb;
  logic [7:0] pass_a, err_a, pass_b, err_b;
  logic [1:0] pass_c, err_c;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  // Target flip-flops, reset to 1 alongside the drivers.
  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (reset) ffq[i] <= 1'b1;
      else begin
        case ({j[i], k[i]})
          2'b10:   ffq[i] <= 1'b1;
          2'b01:   ffq[i] <= 1'b0;
          2'b11:   ffq[i] <= ~ffq[i];
          default: ;
        endcase
      end
    end
  end

  assign q_fb = stuck ? 3'b111 : ffq;

  jk_excitation_driver #(.DEPTH(4), .CNT_W(8), .TOGGLE_PREF(1'b0), .RESET_Q(1'b1)) dut_a (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready[0]), .in_bit(in_bit),
    .j(j[0]), .k(k[0]), .q_fb(q_fb[0]), .busy(busy[0]), .mismatch(mismatch[0]),
    .pass_cnt(pass_a), .err_cnt(err_a)
  );

  jk_excitation_driver #(.DEPTH(4), .CNT_W(8), .TOGGLE_PREF(1'b1), .RESET_Q(1'b1)) dut_b (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready[1]), .in_bit(in_bit),
    .j(j[1]), .k(k[1]), .q_fb(q_fb[1]), .busy(busy[1]), .mismatch(mismatch[1]),
    .pass_cnt(pass_b), .err_cnt(err_b)
  );

  jk_excitation_driver #(.DEPTH(4), .CNT_W(2), .TOGGLE_PREF(1'b0), .RESET_Q(1'b1)) dut_c (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready[2]), .in_bit(in_bit),
    .j(j[2]), .k(k[2]), .q_fb(q_fb[2]), .busy(busy[2]), .mismatch(mismatch[2]),
    .pass_cnt(pass_c), .err_cnt(err_c)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected jk for set/clear drivers (a, c) and the toggle driver (b).
  task automatic chk_jk(input string tag, input logic [1:0] ea, input logic [1:0] eb);
    chk({tag, "_jk_a"}, {30'd0, j[0], k[0]}, {30'd0, ea});
    chk({tag, "_jk_b"}, {30'd0, j[1], k[1]}, {30'd0, eb});
    chk({tag, "_jk_c"}, {30'd0, j[2], k[2]}, {30'd0, ea});
  endtask

  task automatic chk_all(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    chk(tag, {29'd0, obs}, {29'd0, exp});
  endtask

  task automatic chk_cnt(input string tag, input int pa, input int pc, input int ea, input int ec);
    chk({tag, "_pass_a"}, {24'd0, pass_a}, pa);
    chk({tag, "_pass_b"}, {24'd0, pass_b}, pa);
    chk({tag, "_pass_c"}, {30'd0, pass_c}, pc);
    chk({tag, "_err_a"}, {24'd0, err_a}, ea);
    chk({tag, "_err_b"}, {24'd0, err_b}, ea);
    chk({tag, "_err_c"}, {30'd0, err_c}, ec);
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_bit = 1'b0; stuck = 1'b0;
    tick(); tick();
    reset = 1'b0;
    chk_jk("rst", 2'b00, 2'b00);
    chk_all("rst_ready", in_ready, 3'b111);
    chk_all("rst_busy", busy, 3'b000);
    chk_all("rst_q", ffq, 3'b111);
    chk_cnt("rst", 0, 0, 0, 0);

    // Stream 0,1,1,0 back-to-back from pred=1.
    in_valid = 1'b1; in_bit = 1'b0; tick();
    in_bit = 1'b1; tick();
    chk_jk("seq0", 2'b01, 2'b11);
    in_bit = 1'b1; tick();
    chk_jk("seq1", 2'b10, 2'b11);
    chk_all("seq_q0", ffq, 3'b000);
    in_bit = 1'b0; tick();
    chk_jk("seq2", 2'b00, 2'b00);
    chk_all("seq_q1", ffq, 3'b111);
    in_valid = 1'b0; tick();
    chk_jk("seq3", 2'b01, 2'b11);
    chk_all("seq_q2", ffq, 3'b111);
    tick();
    chk_all("seq_q3", ffq, 3'b000);
    chk_all("seq_busy_hi", busy, 3'b111);
    chk_jk("seq_hold", 2'b00, 2'b00);
    tick();
    chk_all("seq_busy_lo", busy, 3'b000);
    chk_all("seq_mm", mismatch, 3'b000);
    chk_cnt("seq", 4, 3, 0, 0);

    // q_fb stuck at 1 with zero targets: two resyncs let the FIFO fill and block.
    reset = 1'b1; tick(); reset = 1'b0;
    chk_cnt("rst2", 0, 0, 0, 0);
    stuck = 1'b1; in_valid = 1'b1; in_bit = 1'b0;
    tick();                                   // e1: b0
    tick();                                   // e2: b1, issue b0
    chk_jk("stk_e2", 2'b01, 2'b11);
    tick();                                   // e3
    chk_jk("stk_e3", 2'b00, 2'b00);
    chk_all("stk_mm_e3", mismatch, 3'b000);
    tick();                                   // e4: check of b0 fails
    chk_all("stk_mm_e4", mismatch, 3'b111);
    chk_cnt("stk_e4", 0, 0, 1, 1);
    chk_all("stk_busy_e4", busy, 3'b111);
    tick();                                   // e5
    chk_all("stk_mm_e5", mismatch, 3'b000);
    chk_jk("stk_e5", 2'b00, 2'b00);
    tick();                                   // e6
    chk_jk("stk_e6", 2'b00, 2'b00);
    chk_cnt("stk_e6", 0, 0, 1, 1);
    in_bit = 1'b1; tick();                    // e7: b6, issue b3 with pred resynced to 1
    chk_jk("stk_e7", 2'b01, 2'b11);
    in_bit = 1'b0; tick();                    // e8: b7
    chk_jk("stk_e8", 2'b00, 2'b00);
    in_bit = 1'b1; tick();                    // e9: b8, check of b3 fails
    chk_all("stk_mm_e9", mismatch, 3'b111);
    chk_cnt("stk_e9", 0, 0, 2, 2);
    in_bit = 1'b1; tick();                    // e10: b9 fills FIFO
    chk_all("full_e10", in_ready, 3'b000);
    stuck = 1'b0;
    in_bit = 1'b0; tick();                    // e11: b10 blocked
    chk_all("full_e11", in_ready, 3'b000);
    chk_jk("stk_e11", 2'b00, 2'b00);
    tick();                                   // e12: pop b6, push still blocked
    chk_all("full_e12", in_ready, 3'b111);
    chk_jk("ord_b6", 2'b10, 2'b00);
    tick();                                   // e13: b10 accepted
    in_valid = 1'b0;
    chk_jk("ord_b7", 2'b01, 2'b11);
    tick();
    chk_jk("ord_b8", 2'b10, 2'b11);
    tick();
    chk_jk("ord_b9", 2'b00, 2'b00);
    tick();
    chk_jk("ord_b10", 2'b01, 2'b11);
    tick();
    chk_all("ord_busy_hi", busy, 3'b111);
    tick();
    chk_all("ord_busy_lo", busy, 3'b000);
    chk_all("ord_mm", mismatch, 3'b000);
    chk_cnt("ord", 5, 3, 2, 2);

    // Reset in the middle of traffic.
    in_valid = 1'b1; in_bit = 1'b1; tick(); tick();
    reset = 1'b1; tick();
    reset = 1'b0; in_valid = 1'b0;
    chk_all("mrst_busy", busy, 3'b000);
    chk_all("mrst_ready", in_ready, 3'b111);
    chk_jk("mrst", 2'b00, 2'b00);
    chk_cnt("mrst", 0, 0, 0, 0);
    in_valid = 1'b1; in_bit = 1'b0; tick();
    in_valid = 1'b0; tick();
    chk_jk("mrst_pred", 2'b01, 2'b11);
    tick(); tick();
    chk_cnt("mrst_after", 1, 1, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/jk_excitation_driver.md
Name: jk_excitation_driver

Overview:
- Drive side of the JK flip-flop interface.
- Accepts a stream of target next-state bits through a valid/ready handshake and buffers them in a small FIFO.
- Converts each target into registered J/K excitation for an external JK flip-flop, using a shadow model of the FF state.
- Checks the FF's q feedback two cycles after each issue, counts passes and mismatches, and resynchronises its shadow state after any mismatch.

Parameters:
- DEPTH, 4: FIFO entries; power of two, at least 2.
- CNT_W, 8: width of the pass and error counters; both counters saturate.
- TOGGLE_PREF, 0: when a state change is required, 1 drives J=K=1 (toggle); 0 drives 10 (set) or 01 (clear).
- RESET_Q, 1: shadow-state value at reset; must equal the target FF's reset value.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high; resets this block and is shared with the target FF.
- in_valid  in  1  target bit offered.
- in_ready  out  1  FIFO can accept a bit.
- in_bit  in  1  desired FF state after the corresponding issue.
- j  out  1  registered J excitation.
- k  out  1  registered K excitation.
- q_fb  in  1  q output of the target FF.
- busy  out  1  FIFO not empty, a check in flight, or not in RUN.
- mismatch  out  1  one-cycle registered pulse on a check failure.
- pass_cnt  out  CNT_W  checks passed; saturating.
- err_cnt  out  CNT_W  mismatches; saturating.

Behaviour:
- Reset (synchronous): FIFO empty, j=k=0, pred=RESET_Q, check stages invalid, mismatch=0, pass_cnt=err_cnt=0, state=RUN. in_ready is 1 in the first cycle after reset.
- Reset asserted mid-operation discards all FIFO contents and in-flight checks.
- Push: a bit is pushed when in_valid && in_ready. in_ready = !full and depends only on registered state, never on the same-cycle pop. A full FIFO therefore blocks pushes even in a cycle where a pop occurs.
- Pop/issue: pop occurs when state==RUN and the FIFO is not empty. On a pop with target t:
  - pred=0,t=0 -> jk=00
  - pred=0,t=1 -> jk=10, or 11 if TOGGLE_PREF
  - pred=1,t=1 -> jk=00
  - pred=1,t=0 -> jk=01, or 11 if TOGGLE_PREF
  - pred <= t; check stage 1 <= {valid, t}.
- Without a pop, j=k=0 (hold).
- Issue cadence: one issue per cycle maximum; back-to-back issues are allowed.
- Check timing: j/k registered at edge E1, FF samples at E2, q_fb valid after E2. Stage 1 moves to stage 2 at E2. At E3, if stage 2 is valid, compare q_fb against its t.
- Equal result: pass_cnt += 1, saturating at all-ones.
- Unequal result: err_cnt += 1 (saturating), mismatch=1 for one cycle, state -> RESYNC1.
- FSM:
  - RUN: normal issue.
  - RESYNC1: no pop, jk=00, both check stages invalidated; those discarded checks are not counted.
  - RESYNC2: no pop, jk=00; at exit pred <= q_fb; then back to RUN.
- Only one mismatch is recorded per resync event, because the pending stages are flushed on entry to RESYNC1.
- Pushes remain accepted during RESYNC while the FIFO is not full.
- Pointers use log2(DEPTH)+1 bits; wrap-around is natural.
- Counter rules: pass_cnt and err_cnt never wrap.
- busy = !empty || stage1.valid || stage2.valid || state!=RUN.

Test Plan:
- Reset with a jkff attached (q=1) -> j=k=0, in_ready=1, busy=0, pass_cnt=err_cnt=0.
- TOGGLE_PREF=0, push 0,1,1,0 back-to-back -> jk sequence 01,10,00,01 on consecutive cycles; q 0,1,1,0; pass_cnt=4, err_cnt=0; busy falls 2 cycles after the last issue.
- TOGGLE_PREF=1, same stimulus -> jk 11,11,00,11; same q sequence and counts.
- Force q_fb stuck at 1, push 0 then 0 -> mismatch pulses exactly 2 cycles after the first issue; err_cnt=1 (second check flushed); 2 cycles of jk=00; pred=1 after resync; the next issue for the queued 0 is 01.
- During RESYNC, push 6 bits back-to-back with DEPTH=4 -> in_ready=0 after the 4th push; the remaining bits are held until pops resume; all bits are issued in order.
- CNT_W=2, 5 passing bits -> pass_cnt stays at 3. Then assert reset with 3 bits queued -> FIFO empty, counts 0, pred=1, jk=00.
